// File: rtl/lstm_gate_pkg.sv
// Shared types and arithmetic helpers for the sequential LSTM gate pre-activation engine.
package lstm_gate_pkg;

    // Widest accumulator the saturating helper supports.
    localparam int unsigned MAX_W = 160;

    typedef enum logic [1:0] {
        WSEL_X = 2'd0,
        WSEL_H = 2'd1,
        WSEL_B = 2'd2
    } w_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Accumulator width that holds 2*N_IN full-precision products plus the bias.
    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned n_in);
        return 2 * dw + $clog2(2 * n_in + 2);
    endfunction

    // Arithmetic right shift by frac, then clamp to the signed dw-bit range.
    function automatic logic signed [MAX_W-1:0] sat_dw(input logic signed [MAX_W-1:0] acc,
                                                       input int unsigned dw,
                                                       input int unsigned frac);
        logic signed [MAX_W-1:0] sh;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        sh = acc >>> frac;
        hi = (MAX_W'(1) << (dw - 1)) - MAX_W'(1);
        lo = ~hi;
        if (sh > hi) begin
            return hi;
        end else if (sh < lo) begin
            return lo;
        end
        return sh;
    endfunction

endpackage

// File: rtl/lstm_gate_preact_seq_mac_lane.sv
// One output column: bias load, multiply-accumulate and saturated readout register.
module mac_lane
    import lstm_gate_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned ACC_W = 72,
    parameter int unsigned FRAC  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_b_i,
    input  logic          mac_i,
    input  logic          cap_i,
    input  logic [DW-1:0] w_i,
    input  logic [DW-1:0] opnd_i,
    output logic [DW-1:0] res_o
);

    localparam int unsigned PW = 2 * DW;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [DW-1:0]    res_q, res_d;
    logic signed [PW-1:0]    w_ext, o_ext, prod;

    always_comb begin
        w_ext = PW'($signed(w_i));
        o_ext = PW'($signed(opnd_i));
        prod  = w_ext * o_ext;
        acc_d = acc_q;
        res_d = res_q;
        if (load_b_i) begin
            acc_d = ACC_W'($signed(w_i)) <<< FRAC;
        end else if (mac_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
        // Readout sees the final MAC of the block in the same cycle.
        if (cap_i) begin
            res_d = DW'(sat_dw(MAX_W'(acc_d), DW, FRAC));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/lstm_gate_preact_seq.sv
// Time-multiplexed LSTM gate pre-activation: streams bias/Wx/Wh rows per column block
// through LANES MAC lanes and hands each saturated block out over a valid/ready port.
module lstm_gate_preact_seq
    import lstm_gate_pkg::*;
#(
    parameter int unsigned N_IN  = 100,
    parameter int unsigned N_OUT = 400,
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned FRAC  = 0,
    localparam int unsigned NB    = N_OUT / LANES,
    localparam int unsigned RW    = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int unsigned BW    = (NB > 1) ? $clog2(NB) : 1,
    localparam int unsigned SW    = $clog2(2 * N_IN + 1),
    localparam int unsigned ACC_W = acc_w(DW, N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  h_en,
    input  logic [N_IN*DW-1:0]    x,
    input  logic [N_IN*DW-1:0]    h_prev,
    output logic                  busy,
    output logic                  done,
    output logic                  w_re,
    output logic [1:0]            w_sel,
    output logic [RW-1:0]         w_row,
    output logic [BW-1:0]         w_blk,
    input  logic [LANES*DW-1:0]   w_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BW-1:0]         out_blk,
    output logic [LANES*DW-1:0]   out_data
);

    if ((N_OUT % LANES) != 0) begin : g_bad_lanes
        $error("N_OUT must be a multiple of LANES");
    end
    if (ACC_W > MAX_W) begin : g_bad_acc
        $error("accumulator wider than sat_dw supports");
    end

    state_e          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [BW-1:0]   blk_q, blk_d;
    logic            h_en_q;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            w_re_q, w_re_d;
    w_sel_e          w_sel_q, w_sel_d;
    logic [RW-1:0]   w_row_q, w_row_d;
    logic [BW-1:0]   w_blk_q, w_blk_d;
    logic            out_valid_q, out_valid_d;
    logic [BW-1:0]   out_blk_q, out_blk_d;

    logic            rd_vld_q;
    w_sel_e          rd_sel_q;
    logic [RW-1:0]   rd_row_q;

    logic [DW-1:0]   x_q [N_IN];
    logic [DW-1:0]   h_q [N_IN];

    logic            accept;
    logic [SW-1:0]   last_step;
    logic            ld_b, mac_en, drain;
    logic [DW-1:0]   opnd;

    assign accept    = (state_q == ST_IDLE) && start;
    assign last_step = h_en_q ? SW'(2 * N_IN) : SW'(N_IN);

    // Next state, counters and the registered read/output controls.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        blk_d       = blk_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_blk_d   = out_blk_q;
        w_re_d      = 1'b0;
        w_sel_d     = WSEL_X;
        w_row_d     = '0;
        w_blk_d     = w_blk_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    step_d  = '0;
                    blk_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (step_q == last_step) begin
                    state_d = ST_DRAIN;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            ST_DRAIN: begin
                state_d     = ST_OUT;
                out_valid_d = 1'b1;
                out_blk_d   = blk_q;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (blk_q == BW'(NB - 1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        step_d  = '0;
                        blk_d   = blk_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Step 0 is the bias, then Wx rows, then (optionally) Wh rows.
        if (state_d == ST_FETCH) begin
            w_re_d  = 1'b1;
            w_blk_d = blk_d;
            if (step_d == '0) begin
                w_sel_d = WSEL_B;
            end else if (step_d <= SW'(N_IN)) begin
                w_sel_d = WSEL_X;
                w_row_d = RW'(step_d - SW'(1));
            end else begin
                w_sel_d = WSEL_H;
                w_row_d = RW'(step_d - SW'(N_IN + 1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            blk_q       <= '0;
            h_en_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            w_re_q      <= 1'b0;
            w_sel_q     <= WSEL_X;
            w_row_q     <= '0;
            w_blk_q     <= '0;
            out_valid_q <= 1'b0;
            out_blk_q   <= '0;
            rd_vld_q    <= 1'b0;
            rd_sel_q    <= WSEL_X;
            rd_row_q    <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            blk_q       <= blk_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            w_re_q      <= w_re_d;
            w_sel_q     <= w_sel_d;
            w_row_q     <= w_row_d;
            w_blk_q     <= w_blk_d;
            out_valid_q <= out_valid_d;
            out_blk_q   <= out_blk_d;
            rd_vld_q    <= w_re_q;
            rd_sel_q    <= w_sel_q;
            rd_row_q    <= w_row_q;
            if (accept) begin
                h_en_q <= h_en;
            end
        end
    end

    // Operand snapshot; the sources may change freely once captured.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N_IN; i++) begin
                x_q[i] <= x[i*DW +: DW];
                h_q[i] <= h_prev[i*DW +: DW];
            end
        end
    end

    assign ld_b   = rd_vld_q && (rd_sel_q == WSEL_B);
    assign mac_en = rd_vld_q && (rd_sel_q != WSEL_B);
    assign drain  = (state_q == ST_DRAIN);
    assign opnd   = (rd_sel_q == WSEL_H) ? h_q[rd_row_q] : x_q[rd_row_q];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(
            .DW    (DW),
            .ACC_W (ACC_W),
            .FRAC  (FRAC)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_b_i (ld_b),
            .mac_i    (mac_en),
            .cap_i    (drain),
            .w_i      (w_rdata[l*DW +: DW]),
            .opnd_i   (opnd),
            .res_o    (out_data[l*DW +: DW])
        );
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign w_re      = w_re_q;
    assign w_sel     = w_sel_q;
    assign w_row     = w_row_q;
    assign w_blk     = w_blk_q;
    assign out_valid = out_valid_q;
    assign out_blk   = out_blk_q;

endmodule

// File: tb/tb_lstm_gate_preact_seq.sv
// Directed bench: two engines (FRAC=0 and FRAC=8) share a weight-memory model.
module tb_lstm_gate_preact_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start0, start8, h_en, out_ready;
    logic [127:0] x, h_prev;

    logic         busy0, done0, w_re0, ov0;
    logic [1:0]   w_sel0, w_row0, w_blk0, ob0;
    logic [63:0]  rdata0, od0;
    logic         busy8, done8, w_re8, ov8;
    logic [1:0]   w_sel8, w_row8, w_blk8, ob8;
    logic [63:0]  rdata8, od8;

    logic [31:0]  wx [4][8];
    logic [31:0]  wh [4][8];
    logic [31:0]  bv [8];
    logic [31:0]  exp_a [8];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wh_rd = 0;
    bit use8 = 1'b0;

    always #5 clk = ~clk;

    lstm_gate_preact_seq #(.N_IN(4), .N_OUT(8), .LANES(2), .DW(32), .FRAC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .h_en(h_en), .x(x), .h_prev(h_prev),
        .busy(busy0), .done(done0), .w_re(w_re0), .w_sel(w_sel0), .w_row(w_row0),
        .w_blk(w_blk0), .w_rdata(rdata0), .out_valid(ov0), .out_ready(out_ready),
        .out_blk(ob0), .out_data(od0));

    lstm_gate_preact_seq #(.N_IN(4), .N_OUT(8), .LANES(2), .DW(32), .FRAC(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .h_en(h_en), .x(x), .h_prev(h_prev),
        .busy(busy8), .done(done8), .w_re(w_re8), .w_sel(w_sel8), .w_row(w_row8),
        .w_blk(w_blk8), .w_rdata(rdata8), .out_valid(ov8), .out_ready(out_ready),
        .out_blk(ob8), .out_data(od8));

    wire        v_busy  = use8 ? busy8 : busy0;
    wire        v_done  = use8 ? done8 : done0;
    wire        v_wre   = use8 ? w_re8 : w_re0;
    wire        v_valid = use8 ? ov8 : ov0;
    wire [1:0]  v_blk   = use8 ? ob8 : ob0;
    wire [63:0] v_data  = use8 ? od8 : od0;

    function automatic logic [63:0] mem_rd(input logic [1:0] sel, input logic [1:0] row,
                                           input logic [1:0] blk);
        logic [63:0] r;
        int col;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            col = int'(blk) * 2 + l;
            case (sel)
                2'd0: r[l*32 +: 32] = wx[row][col];
                2'd1: r[l*32 +: 32] = wh[row][col];
                2'd2: r[l*32 +: 32] = bv[col];
                default: r[l*32 +: 32] = 32'hDEADBEEF;
            endcase
        end
        return r;
    endfunction

    // Synchronous 1-cycle memory; garbage on idle cycles exposes mistimed captures.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rdata0 <= w_re0 ? mem_rd(w_sel0, w_row0, w_blk0) : {$urandom, $urandom};
        rdata8 <= w_re8 ? mem_rd(w_sel8, w_row8, w_blk8) : {$urandom, $urandom};
        if (w_re0 && w_sel0 == 2'd1) wh_rd <= wh_rd + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load_base();
        x      = {32'd4, 32'd3, 32'd2, 32'd1};
        h_prev = {32'd1, 32'd1, 32'd1, 32'd1};
        for (int j = 0; j < 8; j++) begin
            bv[j] = 32'(j);
            for (int i = 0; i < 4; i++) begin
                wx[i][j] = 32'd1;
                wh[i][j] = 32'd2;
            end
        end
    endtask

    task automatic load_row0(input logic [31:0] x0, input logic [31:0] w0, input logic [31:0] b);
        x = {96'd0, x0};
        for (int j = 0; j < 8; j++) begin
            bv[j] = b;
            for (int i = 0; i < 4; i++) wx[i][j] = (i == 0) ? w0 : 32'd0;
        end
    endtask

    // One full operation: start, collect 4 blocks, optional 5-cycle stall on stall_blk.
    task automatic run_op(input string nm, input bit hen, input int stall_blk, input int lat);
        int t0;
        bit seen;
        logic [63:0] held;
        logic [1:0] hblk;
        @(negedge clk);
        h_en = hen;
        if (use8) start8 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start0 = 1'b0;
        start8 = 1'b0;
        chk({nm, " busy"}, 64'(v_busy), 64'd1);
        for (int b = 0; b < 4; b++) begin
            seen = 1'b0;
            for (int k = 0; k < 60 && !seen; k++) begin
                if (v_valid) seen = 1'b1; else @(negedge clk);
            end
            chk($sformatf("%s valid_blk%0d", nm, b), 64'(seen), 64'd1);
            chk($sformatf("%s out_blk%0d", nm, b), 64'(v_blk), 64'(b));
            for (int l = 0; l < 2; l++)
                chk($sformatf("%s A[%0d]", nm, b * 2 + l), 64'(v_data[l*32 +: 32]),
                    64'(exp_a[b*2+l]));
            if (b == stall_blk) begin
                held = v_data;
                hblk = v_blk;
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    if (s == 1) start0 = 1'b1;
                    if (s == 2) start0 = 1'b0;
                    chk($sformatf("%s stall_data%0d", nm, s), v_data, held);
                    chk($sformatf("%s stall_blk%0d", nm, s), 64'(v_blk), 64'(hblk));
                    chk($sformatf("%s stall_wre%0d", nm, s), 64'(v_wre), 64'd0);
                    chk($sformatf("%s stall_valid%0d", nm, s), 64'(v_valid), 64'd1);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (v_done) seen = 1'b1; else @(negedge clk);
        end
        chk({nm, " done_seen"}, 64'(seen), 64'd1);
        chk({nm, " latency"}, 64'(cyc - t0), 64'(lat));
        chk({nm, " busy_at_done"}, 64'(v_busy), 64'd0);
        @(negedge clk);
        chk({nm, " done_pulse"}, 64'(v_done), 64'd0);
    endtask

    initial begin
        int n0;
        bit seen;
        rst_n = 1'b0;
        start0 = 1'b0;
        start8 = 1'b0;
        h_en = 1'b0;
        out_ready = 1'b1;
        load_base();
        repeat (3) @(negedge clk);
        chk("rst busy", 64'(busy0), 64'd0);
        chk("rst done", 64'(done0), 64'd0);
        chk("rst w_re", 64'(w_re0), 64'd0);
        chk("rst out_valid", 64'(ov0), 64'd0);
        chk("rst out_data", od0, 64'd0);
        chk("rst w_sel_row_blk", 64'({w_sel0, w_row0, w_blk0, ob0}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Integer MAC, hidden term skipped.
        for (int j = 0; j < 8; j++) exp_a[j] = 32'(10 + j);
        n0 = wh_rd;
        run_op("xonly", 1'b0, -1, 28);
        chk("xonly wh_reads", 64'(wh_rd - n0), 64'd0);

        // Hidden term enabled.
        for (int j = 0; j < 8; j++) exp_a[j] = 32'(18 + j);
        n0 = wh_rd;
        run_op("xh", 1'b1, -1, 44);
        chk("xh wh_reads", 64'(wh_rd - n0), 64'd16);

        // Saturation in both directions.
        load_row0(32'h4000_0000, 32'd4, 32'd0);
        for (int j = 0; j < 8; j++) exp_a[j] = 32'h7FFF_FFFF;
        run_op("sat_pos", 1'b0, -1, 28);
        load_row0(32'hC000_0000, 32'd4, 32'd0);
        for (int j = 0; j < 8; j++) exp_a[j] = 32'h8000_0000;
        run_op("sat_neg", 1'b0, -1, 28);

        // Fixed point, 8 fractional bits: (128<<8 + 256*384) >> 8 = 512.
        use8 = 1'b1;
        load_row0(32'd256, 32'd384, 32'd128);
        for (int j = 0; j < 8; j++) exp_a[j] = 32'd512;
        run_op("frac8", 1'b0, -1, 28);
        use8 = 1'b0;

        // Backpressure on block 1 with a start pulse while busy.
        load_base();
        for (int j = 0; j < 8; j++) exp_a[j] = 32'(10 + j);
        run_op("stall", 1'b0, 1, 33);

        // Reset in the middle of block 2, then a clean rerun.
        @(negedge clk);
        h_en = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (w_re0 && w_blk0 == 2'd2) seen = 1'b1; else @(negedge clk);
        end
        chk("midrst reach_blk2", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy0), 64'd0);
        chk("midrst out_valid", 64'(ov0), 64'd0);
        chk("midrst done", 64'(done0), 64'd0);
        chk("midrst w_re", 64'(w_re0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 1'b0, -1, 28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
